// File: rtl/collision_detect.sv
// rtl/collision_detect.sv - per-frame sprite collision arbiter with post-hit grace window
//
// Purpose:
//   Samples the ship, shot and rock draw flags on the pixel stream. Overlaps are
//   accumulated over one active frame. When the last active pixel is reached, one-clk
//   hit pulses are issued. After reset and after every reported ship hit, a frame-counted
//   grace window masks ship hits.
//
// Optional build macro:
//   COLLISION_DEBUG_EN adds o_debug_out with hit counters and the first overlap position.
//
// Ports:
//   i_clk         system clock, one pixel per clock
//   i_reset       synchronous, active-high reset
//   i_pxl_x       current pixel column
//   i_pxl_y       current pixel row
//   i_ship_draw   ship sprite opaque at this pixel
//   i_shot_draw   OR of all shot sprites at this pixel
//   i_rock_draw   per-rock opaque flags at this pixel
//   o_ship_hit    1-clk pulse: ship touched a rock this frame (armed only)
//   o_shot_hit    1-clk pulse: a shot touched any rock this frame
//   o_rock_hit    1-clk pulse per rock touched by ship or shot this frame
//   o_frame_end   1-clk pulse, coincident with the hit pulses
//   o_grace       high while the ship is invulnerable
//   o_debug_out   (COLLISION_DEBUG_EN only) {ship hits, shot hits, first overlap x, y}
module collision_detect #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int N_ROCKS      = 8,
  parameter int GRACE_FRAMES = 120
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [$clog2(WIDTH)-1:0]  i_pxl_x,
  input  logic [$clog2(HEIGHT)-1:0] i_pxl_y,
  input  logic                      i_ship_draw,
  input  logic                      i_shot_draw,
  input  logic [N_ROCKS-1:0]        i_rock_draw,
  output logic                      o_ship_hit,
  output logic                      o_shot_hit,
  output logic [N_ROCKS-1:0]        o_rock_hit,
  output logic                      o_frame_end,
  output logic                      o_grace
`ifdef COLLISION_DEBUG_EN
  ,
  output logic [63:0]               o_debug_out
`endif
);

  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  localparam int GW_MIN = $clog2(GRACE_FRAMES + 1);
  localparam int GW     = (GW_MIN > 8) ? GW_MIN : 8;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [GW-1:0] G_LOAD = GW'(GRACE_FRAMES);
  localparam bit            G_EN   = (GRACE_FRAMES != 0);

  typedef enum logic {
    ST_GRACE = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Stage 1 registers
  logic [XW-1:0]      r_s1_x;
  logic [YW-1:0]      r_s1_y;
  logic               r_s1_ship;
  logic               r_s1_shot;
  logic [N_ROCKS-1:0] r_s1_rock;

  // Per-frame sticky flags
  logic               r_ship_f;
  logic               r_shot_f;
  logic [N_ROCKS-1:0] r_rock_f;
  logic               r_at_last_d;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_gcnt;
  logic [GW-1:0]      w_gcnt_nxt;
  logic               w_ship_hit_nxt;

  logic               w_active;
  logic               w_any_rock;
  logic               w_ov_ship;
  logic               w_ov_shot;
  logic [N_ROCKS-1:0] w_ov_rock;
  logic               w_at_last;
  logic               w_fe;
  logic               w_ship_seen;

  assign w_active   = (r_s1_x <= X_LAST) && (r_s1_y <= Y_LAST);
  assign w_any_rock = |r_s1_rock;
  assign w_ov_ship  = w_active & r_s1_ship & w_any_rock;
  assign w_ov_shot  = w_active & r_s1_shot & w_any_rock;
  assign w_ov_rock  = w_active ? (r_s1_rock & {N_ROCKS{r_s1_ship | r_s1_shot}}) : '0;
  assign w_at_last  = w_active && (r_s1_x == X_LAST) && (r_s1_y == Y_LAST);
  // Rising edge only, so a held last-pixel coordinate ends the frame once
  assign w_fe       = w_at_last & ~r_at_last_d;
  // The last pixel's own overlap belongs to the frame that is ending
  assign w_ship_seen = r_ship_f | w_ov_ship;

  assign o_grace = (r_state == ST_GRACE);

  // Grace/armed state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= G_EN ? ST_GRACE : ST_ARMED;
      r_gcnt  <= G_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_gcnt  <= w_gcnt_nxt;
    end
  end

  // State advances only at frame end
  always_comb begin
    w_state_nxt    = r_state;
    w_gcnt_nxt     = r_gcnt;
    w_ship_hit_nxt = 1'b0;
    if (w_fe) begin
      case (r_state)
        ST_GRACE: begin
          if (r_gcnt <= GW'(1)) begin
            w_state_nxt = ST_ARMED;
            w_gcnt_nxt  = '0;
          end else begin
            w_gcnt_nxt = r_gcnt - GW'(1);
          end
        end
        ST_ARMED: begin
          if (w_ship_seen) begin
            w_ship_hit_nxt = 1'b1;
            w_state_nxt    = G_EN ? ST_GRACE : ST_ARMED;
            w_gcnt_nxt     = G_LOAD;
          end
        end
        default: begin
          w_state_nxt = ST_ARMED;
        end
      endcase
    end
  end

  // Input stage, sticky flags and output pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_ship   <= 1'b0;
      r_s1_shot   <= 1'b0;
      r_s1_rock   <= '0;
      r_ship_f    <= 1'b0;
      r_shot_f    <= 1'b0;
      r_rock_f    <= '0;
      r_at_last_d <= 1'b0;
      o_ship_hit  <= 1'b0;
      o_shot_hit  <= 1'b0;
      o_rock_hit  <= '0;
      o_frame_end <= 1'b0;
    end else begin
      r_s1_x      <= i_pxl_x;
      r_s1_y      <= i_pxl_y;
      r_s1_ship   <= i_ship_draw;
      r_s1_shot   <= i_shot_draw;
      r_s1_rock   <= i_rock_draw;
      r_at_last_d <= w_at_last;
      if (w_fe) begin
        o_ship_hit  <= w_ship_hit_nxt;
        o_shot_hit  <= r_shot_f | w_ov_shot;
        o_rock_hit  <= r_rock_f | w_ov_rock;
        o_frame_end <= 1'b1;
        r_ship_f    <= 1'b0;
        r_shot_f    <= 1'b0;
        r_rock_f    <= '0;
      end else begin
        o_ship_hit  <= 1'b0;
        o_shot_hit  <= 1'b0;
        o_rock_hit  <= '0;
        o_frame_end <= 1'b0;
        r_ship_f    <= r_ship_f | w_ov_ship;
        r_shot_f    <= r_shot_f | w_ov_shot;
        r_rock_f    <= r_rock_f | w_ov_rock;
      end
    end
  end

`ifdef COLLISION_DEBUG_EN
  logic [15:0] r_dbg_ship_cnt;
  logic [15:0] r_dbg_shot_cnt;
  logic [15:0] r_dbg_cur_x;
  logic [15:0] r_dbg_cur_y;
  logic [15:0] r_dbg_rep_x;
  logic [15:0] r_dbg_rep_y;
  logic [15:0] w_first_x;
  logic [15:0] w_first_y;

  // Once the ship flag is set, the captured position is the first one.
  // Otherwise, the overlap happening right now is the first.
  assign w_first_x = r_ship_f ? r_dbg_cur_x : 16'(r_s1_x);
  assign w_first_y = r_ship_f ? r_dbg_cur_y : 16'(r_s1_y);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dbg_ship_cnt <= '0;
      r_dbg_shot_cnt <= '0;
      r_dbg_cur_x    <= '0;
      r_dbg_cur_y    <= '0;
      r_dbg_rep_x    <= '0;
      r_dbg_rep_y    <= '0;
    end else begin
      if (w_ship_hit_nxt && (r_dbg_ship_cnt != 16'hFFFF)) begin
        r_dbg_ship_cnt <= r_dbg_ship_cnt + 16'd1;
      end
      if (w_fe && (r_shot_f | w_ov_shot) && (r_dbg_shot_cnt != 16'hFFFF)) begin
        r_dbg_shot_cnt <= r_dbg_shot_cnt + 16'd1;
      end
      if (w_fe) begin
        if (w_ship_hit_nxt) begin
          r_dbg_rep_x <= w_first_x;
          r_dbg_rep_y <= w_first_y;
        end
      end else if (w_ov_ship && !r_ship_f) begin
        r_dbg_cur_x <= 16'(r_s1_x);
        r_dbg_cur_y <= 16'(r_s1_y);
      end
    end
  end

  assign o_debug_out = {r_dbg_ship_cnt, r_dbg_shot_cnt, r_dbg_rep_x, r_dbg_rep_y};
`endif

endmodule
